window_issue_sequencer: RTL and testbench
=========================================

WINDOW_ISSUE_SEQUENCER -- requirements
Module: window_issue_sequencer

Interface
REQ-001 SHALL have parameter NUM_ALLOC, default 220: number of allocators, one-hot width of issue_sel, legal range 1..255.
REQ-002 SHALL have parameter COORD_W, default 8: width of every coordinate and dimension port.
REQ-003 SHALL have parameter RADIUS_W, default 2: width of the kernel radius port.
REQ-004 SHALL have parameter STRIDE_W, default 3: width of the stride port.
REQ-005 SHALL have ports, one per line:
  clk  in  1  clock, all logic on rising edge
  rst  in  1  reset, synchronous, active-high
  image_w  in  COORD_W  unpadded image width in pixels
  image_h  in  COORD_W  unpadded image height in pixels
  radius  in  RADIUS_W  kernel radius; padded width is image_w+2*radius
  stride  in  STRIDE_W  center step in x and y; 0 is treated as 1
  start  in  1  begin a new raster scan
  advance  in  1  release the next batch after a report
  issue_ready  in  1  allocator side accepts an issue this cycle
  issue_valid  out  1  issue_sel/issue_x/issue_y are valid
  issue_sel  out  NUM_ALLOC  one-hot target allocator
  issue_x, issue_y  out  COORD_W  window origin (top-left) in padded coordinates
  batch_valid  out  1  one-cycle pulse; the bounds below are valid
  x_min, x_max, y_min, y_max  out  COORD_W  batch footprint in padded coordinates, inclusive
  busy  out  1  scan in progress
  done  out  1  scan complete, held high

Function
REQ-006 SHALL implement the states IDLE, ISSUE, REPORT, WAIT and DONE.
REQ-007 SHALL, in IDLE or DONE on start=1, latch image_w, image_h, radius and stride (stride 0 latched as 1), set the center to (0,0), clear done and enter ISSUE the next cycle.
REQ-008 SHALL ignore start in ISSUE, REPORT and WAIT; the latched configuration SHALL NOT change mid-scan.
REQ-009 SHALL go directly to DONE with no issue and no batch_valid when start arrives with image_w=0 or image_h=0.
REQ-010 SHALL, in ISSUE, drive issue_valid=1, issue_x=cx, issue_y=cy and issue_sel with only bit k set, where k is the slot index within the batch, counting from 0.
REQ-011 SHALL count a transfer only when issue_valid and issue_ready are both 1; otherwise all issue outputs and the center SHALL hold.
REQ-012 SHALL advance the raster on each transfer: cx += stride; if the new cx > image_w-1, then cx=0 and cy += stride.
REQ-013 SHALL end the scan when the new cy > image_h-1; last center has cx <= image_w-1 and cy <= image_h-1.
REQ-014 SHALL leave ISSUE for REPORT after the NUM_ALLOC-th transfer of a batch or after the scan-ending transfer, whichever comes first; partial batches are legal.
REQ-015 SHALL accumulate the footprint over each batch: x_min = min(cx), x_max = max(cx+2*radius), y_min = cy of the first issue, y_max = cy+2*radius of the last issue.
REQ-016 SHALL compute all arithmetic at COORD_W+2 bits internally so that no compare or sum wraps.
REQ-017 SHALL truncate footprint outputs to COORD_W bits.
REQ-018 SHALL hold x_min..y_max stable from the REPORT cycle until the first transfer of the next batch.
REQ-019 SHALL assert batch_valid for exactly the one REPORT cycle.
REQ-020 SHALL go from REPORT to DONE if the scan ended, otherwise to WAIT.
REQ-021 SHALL go from WAIT to ISSUE on the cycle after advance=1, with k restarting at 0.
REQ-022 SHALL ignore advance outside WAIT.
REQ-023 SHALL keep issue_valid=0 and issue_sel=0 outside ISSUE.
REQ-024 SHALL drive busy=1 in ISSUE, REPORT and WAIT.
REQ-025 SHALL keep done=1 in DONE until start or rst.

Reset
REQ-026 SHALL, on rst=1, enter IDLE and clear k, cx, cy and all outputs to 0 on the next edge, except x_min, which SHALL reset to all ones.
REQ-027 SHALL let rst abort any state mid-scan, with no batch_valid pulse issued for the aborted batch.
REQ-028 SHALL give rst priority over start, advance and issue_ready in the same cycle.

Verification
REQ-029 Scenario: 4x4 image, radius 1, stride 1, NUM_ALLOC=5, issue_ready=1 -> batches of 5,5,5,1 issues; batch 1 covers (0,0)..(3,0),(0,1) and reports x 0..5, y 0..3; done after the 4th report.
REQ-030 Scenario: 5x5 image, stride 2, radius 0 -> 9 issues at x,y in {0,2,4}, then done.
REQ-031 Scenario: issue_ready low for 3 cycles mid-batch -> issue_x, issue_y and issue_sel hold; no center is skipped or repeated.
REQ-032 Scenario: WAIT with advance held low for 10 cycles -> no issue and bounds stable; advance pulse -> slot 0 issued the next cycle.
REQ-033 Scenario: rst asserted in ISSUE at slot 2 -> next cycle IDLE, all outputs at reset values; a new start rescans from (0,0).
REQ-034 Scenario: start with image_w=0, or stride=0 with a 2x2 image -> immediate done, or 4 issues with stride 1, respectively.

Source files
------------

// File: rtl/window_issue_sequencer.sv
// -----------------------------------------------------------------------------
// window_issue_sequencer
//
// Walks the window centers of an image in raster order and issues one window
// origin per transfer to a bank of NUM_ALLOC allocators. Centers are handed out
// in batches of up to NUM_ALLOC. After each batch the block pulses batch_valid
// with the batch's padded footprint, then waits for advance before it releases
// the next batch.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   image_w, image_h    unpadded image size, latched on start
//   radius              kernel radius, latched on start
//   stride              center step in x and y, latched on start (0 acts as 1)
//   start               begins a scan from IDLE or DONE
//   advance             releases the next batch while waiting
//   issue_ready         allocator side accepts the current issue
//   issue_valid         issue_sel / issue_x / issue_y are valid
//   issue_sel           one-hot slot index within the current batch
//   issue_x, issue_y    window origin in padded coordinates
//   batch_valid         one-cycle pulse; x_min..y_max describe the batch
//   x_min..y_max        inclusive batch footprint in padded coordinates
//   busy                a scan is in progress
//   done                the scan is complete; held until start or rst
//
// Handshake: an issue transfers on a rising edge where issue_valid and
// issue_ready are both high. While issue_valid is high and issue_ready is
// low, every issue output holds. issue_valid never drops without a transfer
// unless rst is asserted.
// -----------------------------------------------------------------------------
module window_issue_sequencer #(
    parameter int NUM_ALLOC = 220,
    parameter int COORD_W   = 8,
    parameter int RADIUS_W  = 2,
    parameter int STRIDE_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COORD_W-1:0]   image_w,
    input  logic [COORD_W-1:0]   image_h,
    input  logic [RADIUS_W-1:0]  radius,
    input  logic [STRIDE_W-1:0]  stride,
    input  logic                 start,
    input  logic                 advance,
    input  logic                 issue_ready,
    output logic                 issue_valid,
    output logic [NUM_ALLOC-1:0] issue_sel,
    output logic [COORD_W-1:0]   issue_x,
    output logic [COORD_W-1:0]   issue_y,
    output logic                 batch_valid,
    output logic [COORD_W-1:0]   x_min,
    output logic [COORD_W-1:0]   x_max,
    output logic [COORD_W-1:0]   y_min,
    output logic [COORD_W-1:0]   y_max,
    output logic                 busy,
    output logic                 done
);

    // Two guard bits so that center + stride and center + 2*radius never wrap.
    localparam int EW = COORD_W + 2;

    localparam logic [7:0]           LAST_K  = 8'(NUM_ALLOC - 1);
    localparam logic [NUM_ALLOC-1:0] SEL_ONE = NUM_ALLOC'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_REPORT,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [COORD_W-1:0]  r_w;
    logic [COORD_W-1:0]  r_h;
    logic [RADIUS_W-1:0] r_radius;
    logic [STRIDE_W-1:0] r_stride;
    logic [COORD_W-1:0]  r_cx;
    logic [COORD_W-1:0]  r_cy;
    logic [7:0]          r_k;
    logic                r_scan_ended;
    logic [COORD_W-1:0]  r_acc_xmin;
    logic [EW-1:0]       r_acc_xmax;
    logic [COORD_W-1:0]  r_acc_ymin;

    logic                w_transfer;
    logic [EW-1:0]       w_cx_sum;
    logic [EW-1:0]       w_cy_sum;
    logic                w_row_wrap;
    logic                w_scan_end;
    logic                w_batch_full;
    logic [COORD_W-1:0]  w_next_cx;
    logic [COORD_W-1:0]  w_next_cy;
    logic [EW-1:0]       w_two_r;
    logic [EW-1:0]       w_win_xmax;
    logic [COORD_W-1:0]  w_nx_xmin;
    logic [EW-1:0]       w_nx_xmax;
    logic [COORD_W-1:0]  w_nx_ymin;
    logic [7:0]          w_k_next;
    logic [NUM_ALLOC-1:0] w_sel_next;

    always_comb begin
        w_transfer   = issue_valid && issue_ready;
        w_cx_sum     = {2'b00, r_cx} + EW'(r_stride);
        w_cy_sum     = {2'b00, r_cy} + EW'(r_stride);
        // r_w is at least 1 whenever a scan runs, so ">= w" equals "> w-1".
        w_row_wrap   = (w_cx_sum >= {2'b00, r_w});
        w_scan_end   = w_row_wrap && (w_cy_sum >= {2'b00, r_h});
        w_batch_full = (r_k == LAST_K);
        w_next_cx    = w_row_wrap ? '0 : w_cx_sum[COORD_W-1:0];
        w_next_cy    = w_row_wrap ? w_cy_sum[COORD_W-1:0] : r_cy;
        w_two_r      = EW'({r_radius, 1'b0});
        w_win_xmax   = {2'b00, r_cx} + w_two_r;
        w_k_next     = r_k + 8'd1;
        w_sel_next   = SEL_ONE << w_k_next;

        // Footprint including the window being transferred now; slot 0 restarts it.
        if (r_k == 8'd0) begin
            w_nx_xmin = r_cx;
            w_nx_xmax = w_win_xmax;
            w_nx_ymin = r_cy;
        end else begin
            w_nx_xmin = (r_cx < r_acc_xmin) ? r_cx : r_acc_xmin;
            w_nx_xmax = (w_win_xmax > r_acc_xmax) ? w_win_xmax : r_acc_xmax;
            w_nx_ymin = r_acc_ymin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_w          <= '0;
            r_h          <= '0;
            r_radius     <= '0;
            r_stride     <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_k          <= '0;
            r_scan_ended <= 1'b0;
            r_acc_xmin   <= '0;
            r_acc_xmax   <= '0;
            r_acc_ymin   <= '0;
            issue_valid  <= 1'b0;
            issue_sel    <= '0;
            issue_x      <= '0;
            issue_y      <= '0;
            batch_valid  <= 1'b0;
            x_min        <= '1;
            x_max        <= '0;
            y_min        <= '0;
            y_max        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            batch_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_w          <= image_w;
                        r_h          <= image_h;
                        r_radius     <= radius;
                        r_stride     <= (stride == '0) ? STRIDE_W'(1) : stride;
                        r_cx         <= '0;
                        r_cy         <= '0;
                        r_k          <= '0;
                        r_scan_ended <= 1'b0;
                        if (image_w == '0 || image_h == '0) begin
                            // Empty image: nothing to issue, finish at once.
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_state     <= S_ISSUE;
                            done        <= 1'b0;
                            busy        <= 1'b1;
                            issue_valid <= 1'b1;
                            issue_sel   <= SEL_ONE;
                            issue_x     <= '0;
                            issue_y     <= '0;
                        end
                    end
                end

                S_ISSUE: begin
                    if (w_transfer) begin
                        r_acc_xmin <= w_nx_xmin;
                        r_acc_xmax <= w_nx_xmax;
                        r_acc_ymin <= w_nx_ymin;
                        r_cx       <= w_next_cx;
                        r_cy       <= w_next_cy;
                        if (w_batch_full || w_scan_end) begin
                            r_state      <= S_REPORT;
                            r_scan_ended <= w_scan_end;
                            issue_valid  <= 1'b0;
                            issue_sel    <= '0;
                            batch_valid  <= 1'b1;
                            x_min        <= w_nx_xmin;
                            x_max        <= w_nx_xmax[COORD_W-1:0];
                            y_min        <= w_nx_ymin;
                            // The last window of the batch sets the bottom edge.
                            y_max        <= r_cy + COORD_W'({r_radius, 1'b0});
                        end else begin
                            r_k       <= w_k_next;
                            issue_sel <= w_sel_next;
                            issue_x   <= w_next_cx;
                            issue_y   <= w_next_cy;
                        end
                    end
                end

                S_REPORT: begin
                    if (r_scan_ended) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (advance) begin
                        r_state     <= S_ISSUE;
                        r_k         <= '0;
                        issue_valid <= 1'b1;
                        issue_sel   <= SEL_ONE;
                        issue_x     <= r_cx;
                        issue_y     <= r_cy;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_issue_sequencer.sv
// -----------------------------------------------------------------------------
// tb_window_issue_sequencer
//
// Drives window_issue_sequencer (NUM_ALLOC = 5) with directed and randomized
// scans. A reference model expands each scan configuration into the list of
// centers and the per-batch footprints; a negedge compare process checks the
// DUT outputs against that list on every cycle.
// -----------------------------------------------------------------------------
module tb_window_issue_sequencer;

    localparam int NA = 5;
    localparam int CW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CW-1:0] image_w = '0;
    logic [CW-1:0] image_h = '0;
    logic [1:0]    radius  = '0;
    logic [2:0]    stride  = '0;
    logic          start   = 1'b0;
    logic          advance = 1'b0;
    logic          issue_ready = 1'b0;

    logic          issue_valid;
    logic [NA-1:0] issue_sel;
    logic [CW-1:0] issue_x;
    logic [CW-1:0] issue_y;
    logic          batch_valid;
    logic [CW-1:0] x_min;
    logic [CW-1:0] x_max;
    logic [CW-1:0] y_min;
    logic [CW-1:0] y_max;
    logic          busy;
    logic          done;

    window_issue_sequencer #(
        .NUM_ALLOC(NA),
        .COORD_W  (CW),
        .RADIUS_W (2),
        .STRIDE_W (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .image_w    (image_w),
        .image_h    (image_h),
        .radius     (radius),
        .stride     (stride),
        .start      (start),
        .advance    (advance),
        .issue_ready(issue_ready),
        .issue_valid(issue_valid),
        .issue_sel  (issue_sel),
        .issue_x    (issue_x),
        .issue_y    (issue_y),
        .batch_valid(batch_valid),
        .x_min      (x_min),
        .x_max      (x_max),
        .y_min      (y_min),
        .y_max      (y_max),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];   // expected centers {x, y}, in issue order
    logic [31:0] exp_b[$];   // expected footprints {x_min, x_max, y_min, y_max}
    int          exp_n[$];   // expected issues per batch

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand a scan configuration into centers and batch footprints.
    task automatic build_model(input int w, input int h, input int r, input int s);
        int ss;
        int cnt;
        int xmn;
        int xmx;
        int ymn;
        int ymx;
        ss  = (s == 0) ? 1 : s;
        cnt = 0;
        xmn = 0;
        xmx = 0;
        ymn = 0;
        ymx = 0;
        if (w == 0 || h == 0) return;
        for (int y = 0; y < h; y += ss) begin
            for (int x = 0; x < w; x += ss) begin
                exp_q.push_back({8'(x), 8'(y)});
                if (cnt == 0) begin
                    xmn = x;
                    xmx = x + 2 * r;
                    ymn = y;
                end else begin
                    if (x < xmn) xmn = x;
                    if (x + 2 * r > xmx) xmx = x + 2 * r;
                end
                ymx = y + 2 * r;
                cnt++;
                if (cnt == NA) begin
                    exp_b.push_back({8'(xmn), 8'(xmx), 8'(ymn), 8'(ymx)});
                    exp_n.push_back(cnt);
                    cnt = 0;
                end
            end
        end
        if (cnt > 0) begin
            exp_b.push_back({8'(xmn), 8'(xmx), 8'(ymn), 8'(ymx)});
            exp_n.push_back(cnt);
        end
    endtask

    // ---------------- compare process ----------------
    int          m_slot = 0;
    int          m_xfers = 0;
    bit          m_wait = 1'b0;
    bit          m_exp_slot0 = 1'b0;
    bit          m_exp_done = 1'b0;
    bit          m_bstable = 1'b0;
    bit          m_prev_stall = 1'b0;
    bit          m_prev_bv = 1'b0;
    logic [31:0] m_last_b = '0;
    logic [NA-1:0] m_oh;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_b.delete();
            exp_n.delete();
            m_slot = 0;
            m_xfers = 0;
            m_wait = 1'b0;
            m_exp_slot0 = 1'b0;
            m_exp_done = 1'b0;
            m_bstable = 1'b0;
            m_prev_stall = 1'b0;
            m_prev_bv = 1'b0;
        end else begin
            if (m_exp_done) begin
                chk("done_after_last_report", done, 1);
                chk("busy_clear_when_done", busy, 0);
                m_exp_done = 1'b0;
            end
            if (m_exp_slot0) begin
                chk("issue_after_advance", issue_valid, 1);
                m_exp_slot0 = 1'b0;
            end
            if (m_prev_stall) chk("issue_valid_hold", issue_valid, 1);
            if (m_bstable) chk("bounds_stable", {x_min, x_max, y_min, y_max}, m_last_b);
            if (m_wait) begin
                chk("wait_no_issue", issue_valid, 0);
                chk("wait_busy", busy, 1);
                if (advance) begin
                    m_wait = 1'b0;
                    m_exp_slot0 = 1'b1;
                end
            end
            if (issue_valid) begin
                chk("busy_in_issue", busy, 1);
                chk("done_in_issue", done, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", issue_valid, 0);
                end else begin
                    m_oh = '0;
                    if (m_slot < NA) m_oh[m_slot] = 1'b1;
                    chk("issue_xy", {issue_x, issue_y}, exp_q[0]);
                    chk("issue_sel", issue_sel, m_oh);
                    if (issue_ready) begin
                        void'(exp_q.pop_front());
                        m_slot++;
                        m_xfers++;
                        m_bstable = 1'b0;
                    end
                end
            end else begin
                chk("sel_zero_when_idle", issue_sel, 0);
            end
            m_prev_stall = issue_valid && !issue_ready;
            if (batch_valid) begin
                if (m_prev_bv) chk("batch_valid_one_cycle", batch_valid, 0);
                if (exp_b.size() == 0) begin
                    chk("unexpected_batch", batch_valid, 0);
                end else begin
                    chk("bounds", {x_min, x_max, y_min, y_max}, exp_b[0]);
                    chk("batch_size", m_xfers, exp_n[0]);
                    m_last_b = exp_b[0];
                    void'(exp_b.pop_front());
                    void'(exp_n.pop_front());
                    m_bstable = 1'b1;
                    m_slot = 0;
                    m_xfers = 0;
                    if (exp_q.size() == 0) m_exp_done = 1'b1;
                    else m_wait = 1'b1;
                end
            end
            m_prev_bv = batch_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_vals();
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_sel", issue_sel, 0);
        chk("rst_issue_x", issue_x, 0);
        chk("rst_issue_y", issue_y, 0);
        chk("rst_batch_valid", batch_valid, 0);
        chk("rst_x_min", x_min, 8'hff);
        chk("rst_x_max", x_max, 0);
        chk("rst_y_min", y_min, 0);
        chk("rst_y_max", y_max, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    task automatic do_start(input int w, input int h, input int r, input int s);
        @(posedge clk); #1;
        image_w = 8'(w);
        image_h = 8'(h);
        radius = 2'(r);
        stride = 3'(s);
        start = 1'b1;
        advance = 1'b0;
        issue_ready = 1'b1;
        build_model(w, h, r, s);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs until done with random back-pressure, random advance delays,
    // stray start/advance pulses and a scrambled configuration bus.
    task automatic run_scan(input int ready_pct, input int wmin, input int wmax);
        int wait_cnt;
        int cyc;
        wait_cnt = -1;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (cyc >= 20000) begin
                chk("scan_timeout", done, 1);
                break;
            end
            if (batch_valid) wait_cnt = $urandom_range(wmax, wmin);
            @(posedge clk); #1;
            issue_ready = ($urandom_range(99, 0) < ready_pct);
            advance = 1'b0;
            start = 1'b0;
            if (wait_cnt == 0) begin
                advance = 1'b1;
                wait_cnt = -1;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
            end else if (exp_q.size() > 0) begin
                advance = ($urandom_range(3, 0) == 0);
                start = ($urandom_range(3, 0) == 0);
            end
            image_w = 8'($urandom);
            image_h = 8'($urandom);
            radius = 2'($urandom);
            stride = 3'($urandom);
            cyc++;
        end
        start = 1'b0;
        advance = 1'b0;
        chk("centers_drained", exp_q.size(), 0);
        chk("batches_drained", exp_b.size(), 0);
    endtask

    task automatic wait_slot(input int slot, output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (issue_valid && issue_sel[slot]) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals();

        // 4x4, radius 1, stride 1: batches 5,5,5,1
        do_start(4, 4, 1, 1);
        chk("model_batches", exp_b.size(), 4);
        chk("model_n0", exp_n[0], 5);
        chk("model_n3", exp_n[3], 1);
        chk("model_b0", exp_b[0], 32'h00_05_00_03);
        chk("model_b3", exp_b[3], 32'h03_05_03_05);
        run_scan(100, 0, 0);
        chk("done_4x4", done, 1);

        // 5x5, stride 2, radius 0: 9 centers on {0,2,4}
        do_start(5, 5, 0, 2);
        chk("model_9_centers", exp_q.size(), 9);
        chk("model_c1", exp_q[1], 16'h0200);
        chk("model_c8", exp_q[8], 16'h0404);
        run_scan(70, 0, 2);

        // issue_ready low for 3 cycles at slot 2
        do_start(4, 4, 1, 1);
        wait_slot(1, found);
        chk("reach_slot1", found, 1);
        @(posedge clk); #1;
        issue_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_x", issue_x, 2);
            chk("stall_y", issue_y, 0);
            chk("stall_sel", issue_sel, 5'b00100);
            @(posedge clk); #1;
        end
        issue_ready = 1'b1;
        run_scan(100, 0, 1);

        // long WAIT before every advance
        do_start(4, 4, 1, 1);
        run_scan(100, 10, 10);

        // reset in ISSUE at slot 2, with start/advance/ready also high
        do_start(4, 4, 1, 1);
        wait_slot(2, found);
        chk("reach_slot2", found, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b1;
        advance = 1'b1;
        issue_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        advance = 1'b0;
        @(negedge clk);
        check_reset_vals();
        do_start(4, 4, 1, 1);
        run_scan(80, 0, 3);

        // empty image: immediate done
        do_start(0, 3, 1, 1);
        @(negedge clk);
        chk("empty_done", done, 1);
        chk("empty_busy", busy, 0);
        chk("empty_no_issue", issue_valid, 0);
        @(negedge clk);
        chk("empty_no_batch", batch_valid, 0);
        chk("empty_done_held", done, 1);

        // stride 0 acts as stride 1
        do_start(2, 2, 0, 0);
        chk("model_stride0", exp_q.size(), 4);
        run_scan(100, 0, 1);

        // single pixel and wide images with truncated footprints
        do_start(1, 1, 3, 5);
        chk("model_1x1_b", exp_b[0], 32'h00_06_00_06);
        run_scan(60, 0, 2);
        do_start(255, 255, 3, 7);
        run_scan(100, 0, 0);

        // random configurations
        for (int t = 0; t < 10; t++) begin
            do_start($urandom_range(12, 1), $urandom_range(12, 1),
                     $urandom_range(3, 0), $urandom_range(7, 0));
            run_scan($urandom_range(100, 30), 0, 3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
